// File: rtl/ctrl_pipe.sv
// ctrl_pipe: consumer end of the decode-stage control bundle.
//
// Carries the D-stage control signals through the E, M and W stage registers.
// Resolves branch/jump outcome from the E register and drives the PC select.
// Requests a D-stage flush on redirect and counts retired instructions.
//
// Optional feature macro: CTRL_PIPE_UNSIGNED_BRANCH_EN
//   defined   -> branchD 101 = BLTU (taken if ltuE), 110 = BGEU (taken if !ltuE)
//   undefined -> codes 101/110 never taken, ltuE ignored
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   validD .. aluCtrlD           decoded D-stage control bundle
//   flushE                       hazard-unit bubble request into E
//   zeroE, ltE, ltuE             ALU flags for branch resolution
//   ALUSrcE, aluCtrlE            E-stage ALU controls
//   resultSrcE, regWriteE        E-stage writeback info (hazard unit)
//   pcSrcE, flushDReq            redirect select and D-stage kill request
//   regWriteM, resultSrcM,
//   memWriteM                    M-stage controls
//   regWriteW, resultSrcW        W-stage controls
//   retired                      retired-instruction count (wraps)
module ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD,
    input  logic             regWriteD,
    input  logic [1:0]       resultSrcD,
    input  logic             memWriteD,
    input  logic [1:0]       jumpD,
    input  logic [2:0]       branchD,
    input  logic             ALUSrcD,
    input  logic [2:0]       aluCtrlD,
    input  logic             flushE,
    input  logic             zeroE,
    input  logic             ltE,
    input  logic             ltuE,
    output logic             ALUSrcE,
    output logic [2:0]       aluCtrlE,
    output logic [1:0]       resultSrcE,
    output logic             regWriteE,
    output logic [1:0]       pcSrcE,
    output logic             flushDReq,
    output logic             regWriteM,
    output logic [1:0]       resultSrcM,
    output logic             memWriteM,
    output logic             regWriteW,
    output logic [1:0]       resultSrcW,
    output logic [CNT_W-1:0] retired
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] jump;
        logic [2:0] branch;
        logic       alu_src;
        logic [2:0] alu_ctrl;
    } e_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } m_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } w_ctrl_t;

    // valid shift register: [1]=E, [2]=M, [3]=W
    logic [3:1]       vld_pipe_d, vld_pipe_q;
    e_ctrl_t          e_d, e_q;
    m_ctrl_t          m_d, m_q;
    w_ctrl_t          w_d, w_q;
    logic [CNT_W-1:0] retired_d, retired_q;

    logic             br_taken;
    logic [1:0]       pc_src;
    logic             bubble;

`ifndef CTRL_PIPE_UNSIGNED_BRANCH_EN
    logic unused_ltu;
    assign unused_ltu = ltuE;
`endif

    // Branch/jump resolution from the E register.
    always_comb begin
        br_taken = 1'b0;
        case (e_q.branch)
            3'b001:  br_taken = zeroE;
            3'b010:  br_taken = ~zeroE;
            3'b011:  br_taken = ltE;
            3'b100:  br_taken = ~ltE;
`ifdef CTRL_PIPE_UNSIGNED_BRANCH_EN
            3'b101:  br_taken = ltuE;
            3'b110:  br_taken = ~ltuE;
`endif
            default: br_taken = 1'b0;
        endcase

        pc_src = 2'b00;
        if (vld_pipe_q[1]) begin
            // jump wins over branch; jump code 11 is reserved (none)
            if (e_q.jump == 2'b01)
                pc_src = 2'b01;
            else if (e_q.jump == 2'b10)
                pc_src = 2'b10;
            else if (br_taken)
                pc_src = 2'b01;
        end
    end

    always_comb begin
        // flushE and redirect collapse into the same single bubble
        bubble        = flushE | (pc_src != 2'b00);
        vld_pipe_d    = {vld_pipe_q[2:1], validD & ~bubble};

        e_d = '0;
        if (vld_pipe_d[1]) begin
            e_d.reg_write  = regWriteD;
            e_d.result_src = resultSrcD;
            e_d.mem_write  = memWriteD;
            e_d.jump       = jumpD;
            e_d.branch     = branchD;
            e_d.alu_src    = ALUSrcD;
            e_d.alu_ctrl   = aluCtrlD;
        end

        m_d.reg_write  = e_q.reg_write;
        m_d.result_src = e_q.result_src;
        m_d.mem_write  = e_q.mem_write;

        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;

        retired_d = retired_q + {{(CNT_W-1){1'b0}}, vld_pipe_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            e_q        <= '0;
            m_q        <= '0;
            w_q        <= '0;
            retired_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            e_q        <= e_d;
            m_q        <= m_d;
            w_q        <= w_d;
            retired_q  <= retired_d;
        end
    end

    assign ALUSrcE    = e_q.alu_src;
    assign aluCtrlE   = e_q.alu_ctrl;
    assign resultSrcE = e_q.result_src;
    assign regWriteE  = e_q.reg_write & vld_pipe_q[1];
    assign pcSrcE     = pc_src;
    assign flushDReq  = (pc_src != 2'b00);
    assign regWriteM  = m_q.reg_write & vld_pipe_q[2];
    assign resultSrcM = m_q.result_src;
    assign memWriteM  = m_q.mem_write & vld_pipe_q[2];
    assign regWriteW  = w_q.reg_write & vld_pipe_q[3];
    assign resultSrcW = w_q.result_src;
    assign retired    = retired_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized
// traffic checked against an instruction-list reference model.
module tb_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, validD, regWriteD, memWriteD, ALUSrcD, flushE, zeroE, ltE, ltuE;
    logic [1:0] resultSrcD, jumpD;
    logic [2:0] branchD, aluCtrlD;

    logic        ALUSrcE, regWriteE, flushDReq, regWriteM, memWriteM, regWriteW;
    logic [2:0]  aluCtrlE;
    logic [1:0]  resultSrcE, pcSrcE, resultSrcM, resultSrcW;
    logic [31:0] retired;
    logic [16:0] o4;
    logic [3:0]  retired4;
    logic [16:0] out_vec;

    assign out_vec = {ALUSrcE, aluCtrlE, resultSrcE, regWriteE, pcSrcE, flushDReq,
                      regWriteM, resultSrcM, memWriteM, regWriteW, resultSrcW};

    ctrl_pipe dut (
        .clk(clk), .rst(rst), .validD(validD), .regWriteD(regWriteD),
        .resultSrcD(resultSrcD), .memWriteD(memWriteD), .jumpD(jumpD),
        .branchD(branchD), .ALUSrcD(ALUSrcD), .aluCtrlD(aluCtrlD),
        .flushE(flushE), .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE),
        .ALUSrcE(ALUSrcE), .aluCtrlE(aluCtrlE), .resultSrcE(resultSrcE),
        .regWriteE(regWriteE), .pcSrcE(pcSrcE), .flushDReq(flushDReq),
        .regWriteM(regWriteM), .resultSrcM(resultSrcM), .memWriteM(memWriteM),
        .regWriteW(regWriteW), .resultSrcW(resultSrcW), .retired(retired)
    );

    // narrow-counter build to exercise wrap
    ctrl_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .validD(validD), .regWriteD(regWriteD),
        .resultSrcD(resultSrcD), .memWriteD(memWriteD), .jumpD(jumpD),
        .branchD(branchD), .ALUSrcD(ALUSrcD), .aluCtrlD(aluCtrlD),
        .flushE(flushE), .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE),
        .ALUSrcE(o4[16]), .aluCtrlE(o4[15:13]), .resultSrcE(o4[12:11]),
        .regWriteE(o4[10]), .pcSrcE(o4[9:8]), .flushDReq(o4[7]),
        .regWriteM(o4[6]), .resultSrcM(o4[5:4]), .memWriteM(o4[3]),
        .regWriteW(o4[2]), .resultSrcW(o4[1:0]), .retired(retired4)
    );

    // ---------------- reference model ----------------
    // hist[0] = instruction now in E, hist[1] in M, hist[2] in W.
    // Killed/empty slots are stored as all-zero.
    typedef struct packed {
        logic       v;
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic [1:0] j;
        logic [2:0] br;
        logic       as;
        logic [2:0] alu;
    } ins_t;

    ins_t        hist [3];
    int unsigned ret_cnt;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    function automatic logic [1:0] pc_rule(ins_t i, logic z, logic lt, logic ltu);
        logic tk;
        if (!i.v) return 2'b00;
        if (i.j == 2'b01) return 2'b01;
        if (i.j == 2'b10) return 2'b10;
        tk = (i.br == 3'd1 && z) || (i.br == 3'd2 && !z) ||
             (i.br == 3'd3 && lt) || (i.br == 3'd4 && !lt);
`ifdef CTRL_PIPE_UNSIGNED_BRANCH_EN
        tk = tk || (i.br == 3'd5 && ltu) || (i.br == 3'd6 && !ltu);
`else
        tk = tk && (ltu || !ltu);
`endif
        return tk ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [16:0] exp_outs();
        logic [1:0] pc;
        pc = pc_rule(hist[0], zeroE, ltE, ltuE);
        return {hist[0].as, hist[0].alu, hist[0].rs, hist[0].rw & hist[0].v, pc, pc != 2'b00,
                hist[1].rw & hist[1].v, hist[1].rs, hist[1].mw & hist[1].v,
                hist[2].rw & hist[2].v, hist[2].rs};
    endfunction

    task automatic tick();
        logic [1:0] pc;
        @(posedge clk);
        if (rst) begin
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
            ret_cnt = 0;
        end else begin
            pc = pc_rule(hist[0], zeroE, ltE, ltuE);
            ret_cnt = ret_cnt + (hist[2].v ? 1 : 0);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (validD && !flushE && pc == 2'b00) ?
                      {1'b1, regWriteD, resultSrcD, memWriteD, jumpD, branchD, ALUSrcD, aluCtrlD} : '0;
        end
        @(negedge clk);
    endtask

    task automatic drive(logic v, logic rw, logic [1:0] rs, logic mw, logic [1:0] j,
                         logic [2:0] br, logic as, logic [2:0] alu,
                         logic fl, logic z, logic lt, logic ltu);
        validD = v; regWriteD = rw; resultSrcD = rs; memWriteD = mw; jumpD = j;
        branchD = br; ALUSrcD = as; aluCtrlD = alu; flushE = fl; zeroE = z;
        ltE = lt; ltuE = ltu;
        #1;
    endtask

    task automatic drain(int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 2'b11, 1, 2'b11, 3'b111, 1, 3'b111, 1, 1, 1, 1);
        tick(); tick();
        chk_cnt++; if (out_vec !== 17'd0) $display("FAIL reset_outs got %h exp %h", out_vec, 17'd0); else pass_cnt++;
        chk_cnt++; if (retired !== 32'd0) $display("FAIL reset_retired got %0d exp 0", retired); else pass_cnt++;
        rst = 1'b0;
        drive(1, 1, 2'b00, 0, 2'b00, 3'b000, 0, 3'b010, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (regWriteE !== 1'b1) $display("FAIL lat_E got %b exp 1", regWriteE); else pass_cnt++;
        chk_cnt++; if (aluCtrlE !== 3'b010) $display("FAIL lat_aluE got %b exp 010", aluCtrlE); else pass_cnt++;
        tick();
        chk_cnt++; if (regWriteM !== 1'b1 || regWriteW !== 1'b0) $display("FAIL lat_M got M=%b W=%b exp M=1 W=0", regWriteM, regWriteW); else pass_cnt++;
        tick();
        chk_cnt++; if (regWriteW !== 1'b1) $display("FAIL lat_W got %b exp 1", regWriteW); else pass_cnt++;
        chk_cnt++; if (retired !== 32'd0) $display("FAIL ret_before got %0d exp 0", retired); else pass_cnt++;
        tick();
        chk_cnt++; if (retired !== 32'd1) $display("FAIL ret_after got %0d exp 1", retired); else pass_cnt++;
    endtask

    task automatic test_branch();
        int unsigned r0;
        drain(4);
        r0 = ret_cnt;
        drive(1, 0, 0, 0, 0, 3'b001, 0, 3'b001, 0, 0, 0, 0);   // BEQ
        tick();
        drive(1, 1, 0, 0, 0, 3'b000, 0, 3'b000, 0, 1, 0, 0);   // add, zeroE=1
        chk_cnt++; if (pcSrcE !== 2'b01 || flushDReq !== 1'b1) $display("FAIL beq_taken got pc=%b fl=%b exp pc=01 fl=1", pcSrcE, flushDReq); else pass_cnt++;
        chk_cnt++; if (out_vec !== exp_outs()) $display("FAIL beq_taken_vec got %h exp %h", out_vec, exp_outs()); else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (regWriteE !== 1'b0) $display("FAIL beq_bubble got %b exp 0", regWriteE); else pass_cnt++;
        drain(4);
        chk_cnt++; if (retired !== r0 + 1) $display("FAIL beq_taken_ret got %0d exp %0d", retired, r0 + 1); else pass_cnt++;
        drive(1, 0, 0, 0, 0, 3'b001, 0, 3'b001, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);   // zeroE=0
        chk_cnt++; if (pcSrcE !== 2'b00 || flushDReq !== 1'b0) $display("FAIL beq_not got pc=%b fl=%b exp pc=00 fl=0", pcSrcE, flushDReq); else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (regWriteE !== 1'b1) $display("FAIL beq_not_nobubble got %b exp 1", regWriteE); else pass_cnt++;
        drain(4);
        chk_cnt++; if (retired !== r0 + 3) $display("FAIL beq_not_ret got %0d exp %0d", retired, r0 + 3); else pass_cnt++;
    endtask

    task automatic test_jump();
        drain(4);
        drive(1, 1, 2'b10, 0, 2'b10, 3'b001, 0, 3'b000, 0, 0, 0, 0);   // jalr + BEQ code
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk_cnt++; if (pcSrcE !== 2'b10 || flushDReq !== 1'b1) $display("FAIL jalr_prio got pc=%b fl=%b exp pc=10 fl=1", pcSrcE, flushDReq); else pass_cnt++;
        tick(); tick();
        chk_cnt++; if (resultSrcW !== 2'b10 || regWriteW !== 1'b1) $display("FAIL jalr_W got rs=%b rw=%b exp rs=10 rw=1", resultSrcW, regWriteW); else pass_cnt++;
    endtask

    task automatic test_load_use();
        int unsigned r0;
        drain(4);
        r0 = ret_cnt;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // flushE with valid add
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (regWriteE !== 1'b0 || regWriteM !== 1'b1) $display("FAIL lu_bubble got E=%b M=%b exp E=0 M=1", regWriteE, regWriteM); else pass_cnt++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt++; if (regWriteM !== 1'b0 || memWriteM !== 1'b0) $display("FAIL lu_M got rw=%b mw=%b exp 0 0", regWriteM, memWriteM); else pass_cnt++;
        drain(4);
        chk_cnt++; if (retired !== r0 + 2) $display("FAIL lu_ret got %0d exp %0d", retired, r0 + 2); else pass_cnt++;
    endtask

    task automatic test_store();
        int unsigned r0;
        drain(4);
        r0 = ret_cnt;
        drive(1, 0, 2'b00, 1, 0, 0, 1, 3'b000, 0, 0, 0, 0);   // store
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k <= 5) drive(1, 1, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk_cnt++; if (memWriteM !== (k == 2)) $display("FAIL store_pulse k=%0d got %b exp %b", k, memWriteM, (k == 2)); else pass_cnt++;
            tick();
        end
        drain(2);
        chk_cnt++; if (retired !== r0 + 6) $display("FAIL store_ret got %0d exp %0d", retired, r0 + 6); else pass_cnt++;
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        drain(1);
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drain(4);
        chk_cnt++; if (retired4 !== 4'd1) $display("FAIL wrap4 got %0d exp 1", retired4); else pass_cnt++;
        chk_cnt++; if (retired !== 32'd17) $display("FAIL wrap32 got %0d exp 17", retired); else pass_cnt++;
    endtask

    task automatic test_unsigned();
        logic [1:0] exp_pc;
`ifdef CTRL_PIPE_UNSIGNED_BRANCH_EN
        exp_pc = 2'b01;
`else
        exp_pc = 2'b00;
`endif
        drain(4);
        drive(1, 0, 0, 0, 0, 3'b101, 0, 0, 0, 0, 0, 1);   // BLTU code
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_cnt++; if (pcSrcE !== exp_pc) $display("FAIL bltu got %b exp %b", pcSrcE, exp_pc); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00,
                  ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                  1'($urandom), 3'($urandom),
                  $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
            chk_cnt++; if (out_vec !== exp_outs()) $display("FAIL rnd_vec k=%0d got %h exp %h", k, out_vec, exp_outs()); else pass_cnt++;
            chk_cnt++; if (o4 !== exp_outs()) $display("FAIL rnd_vec4 k=%0d got %h exp %h", k, o4, exp_outs()); else pass_cnt++;
            chk_cnt++; if (retired !== ret_cnt || retired4 !== ret_cnt[3:0]) $display("FAIL rnd_ret k=%0d got %0d/%0d exp %0d", k, retired, retired4, ret_cnt); else pass_cnt++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        ret_cnt = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_branch();
        test_jump();
        test_load_use();
        test_store();
        test_wrap();
        test_unsigned();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decode-stage control bundle. Registers the D-stage control signals through the E, M and W pipeline stages.
- Resolves branch and jump outcome in E, drives PC select, and requests the D-stage flush on redirect.
- Counts retired instructions. Sits between the main decoder and the datapath stage registers.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- validD  in  1  D-stage slot holds a real instruction
- regWriteD  in  1  decoded register-file write enable
- resultSrcD  in  2  decoded writeback select (00 ALU, 01 mem, 10 PC+4, 11 imm)
- memWriteD  in  1  decoded store enable
- jumpD  in  2  01 jal, 10 jalr, others none
- branchD  in  3  001 BEQ, 010 BNE, 011 BLT, 100 BGE, 000 none
- ALUSrcD  in  1  decoded ALU B-operand select
- aluCtrlD  in  3  ALU operation from ALU decoder
- flushE  in  1  hazard-unit bubble request (load-use)
- zeroE  in  1  ALU result == 0
- ltE  in  1  signed A < B
- ltuE  in  1  unsigned A < B (used only with macro)
- ALUSrcE  out  1  E-stage ALU operand select
- aluCtrlE  out  3  E-stage ALU operation
- resultSrcE  out  2  for hazard unit load detect
- regWriteE  out  1  E-stage write enable (gated by validE)
- pcSrcE  out  2  00 PC+4, 01 PC+imm, 10 ALU result
- flushDReq  out  1  kill F/D register next edge
- regWriteM  out  1  M-stage write enable
- resultSrcM  out  2  M-stage writeback select
- memWriteM  out  1  data-memory write enable
- regWriteW  out  1  W-stage write enable
- resultSrcW  out  2  W-stage writeback select
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Registers: E, M and W stage registers, each holding a valid bit plus its control fields.
  - E holds all D fields.
  - M holds regWrite, resultSrc and memWrite.
  - W holds regWrite and resultSrc.
- Reset: on a clk edge with rst=1, all valid bits, control fields and retired become 0. All outputs read 0 the following cycle. Reset mid-operation discards in-flight state with no partial update.
- Bubble rule: E loads all-zero (valid=0) when flushE=1 OR pcSrcE!=00. Otherwise E loads the D bundle, with valid=validD.
  - When validD=0, all loaded fields are forced 0.
  - Simultaneous flushE and redirect produce a single bubble, same result.
- M loads from E and W loads from M every cycle. There is no stall on E, M or W.
- Output gating: regWriteE/M/W and memWriteM are each ANDed with their stage valid bit.
- Branch resolution (combinational from E register, only when validE=1; else pcSrcE=00):
  - jumpE=01 -> pcSrcE=01.
  - jumpE=10 -> pcSrcE=10. Jump takes priority over branch.
  - jumpE=11 is reserved and treated as none.
  - branchE taken conditions: 001 zeroE; 010 !zeroE; 011 ltE; 100 !ltE. Taken -> pcSrcE=01.
  - Codes 000, 101, 110 and 111 are not taken unless extended by the macro.
- flushDReq = (pcSrcE!=00). Combinational, same cycle as pcSrcE.
- Latency: a D bundle appears on E outputs 1 cycle after capture, M after 2, W after 3.
- Retired counter: retired increments by 1 on each edge where validW=1.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
  - The count is visible the cycle after W.

Optional Feature:
- CTRL_PIPE_UNSIGNED_BRANCH_EN
- Defined: branchD 101 = BLTU (taken if ltuE) and 110 = BGEU (taken if !ltuE), both producing pcSrcE=01.
- Undefined: codes 101 and 110 are never taken, ltuE is ignored, and no logic is generated for it.

Test Plan:
- Reset held 2 cycles with all inputs active -> all outputs 0 and retired=0. Release -> first valid bundle reaches regWriteW=1 exactly 3 edges after capture.
- BEQ, validD=1, then zeroE=1 in E -> pcSrcE=01 and flushDReq=1. The next E is a bubble (regWriteE=0), and the following instruction is never retired. With zeroE=0 -> pcSrcE=00 and no bubble.
- jalr with branchD=001 and zeroE=1 simultaneously -> pcSrcE=10 (jump priority). resultSrcW=10 three cycles later.
- Load-use: flushE=1 for 1 cycle while a valid add is in D -> E bubble, memWriteM=0 and regWriteM=0 next cycle. retired increases by 1 fewer than instructions issued.
- Store (memWriteD=1) followed by 5 valid ALU ops -> memWriteM pulses exactly 1 cycle, 2 edges after capture. retired=6 after draining.
- Counter preloaded via CNT_W=4 build, 17 valid retirements -> retired=1 (wrap). Macro on: branchD=101, ltuE=1 -> pcSrcE=01. Macro off: same stimulus -> pcSrcE=00.
